// File: rtl/product_accumulator_serializer.sv
// Accumulates COUNT products from the multiplier, then streams the sum out
// one byte per handshake, least-significant byte first.
module product_accumulator_serializer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned COUNT  = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DATA_W-1:0] prod_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned NBYTES = ACC_W / 8;
  localparam int unsigned IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic        SINGLE_BYTE = (NBYTES == 1);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_EMIT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ACC_W-1:0]   shreg_q, shreg_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic [7:0]         out_data_q, out_data_d;

  // Sum with carry bit, and the result shifted down to expose the next byte
  logic [ACC_W:0]     sum_c;
  logic [ACC_W-1:0]   shreg_nxt_c;
  logic               last_cnt_c;
  logic               last_idx_c;

  assign sum_c       = {1'b0, acc_q} + (ACC_W+1)'(prod_in);
  assign shreg_nxt_c = shreg_q >> 8;
  assign last_cnt_c  = (cnt_q == CNT_W'(COUNT - 1));
  assign last_idx_c  = (idx_q == IDX_W'(NBYTES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (clr) begin
      // Abort: same end state as reset, any pending product is dropped
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      idx_d       = '0;
      shreg_d     = '0;
      ovf_d       = 1'b0;
      busy_d      = 1'b0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
    end else begin
      case (state_q)
        ST_ACC: begin
          if (in_valid) begin
            acc_d  = sum_c[ACC_W-1:0];
            ovf_d  = ovf_q | sum_c[ACC_W];
            cnt_d  = cnt_q + 1'b1;
            busy_d = 1'b1;
            if (last_cnt_c) begin
              state_d     = ST_EMIT;
              shreg_d     = sum_c[ACC_W-1:0];
              idx_d       = '0;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
              out_last_d  = SINGLE_BYTE;
              out_data_d  = sum_c[7:0];
            end
          end
        end
        ST_EMIT: begin
          if (out_ready) begin
            if (last_idx_c) begin
              state_d     = ST_ACC;
              acc_d       = '0;
              cnt_d       = '0;
              idx_d       = '0;
              ovf_d       = 1'b0;
              busy_d      = 1'b0;
              in_ready_d  = 1'b1;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              out_data_d  = '0;
            end else begin
              idx_d      = idx_q + 1'b1;
              shreg_d    = shreg_nxt_c;
              out_data_d = shreg_nxt_c[7:0];
              out_last_d = (idx_q + 1'b1 == IDX_W'(NBYTES - 1));
            end
          end
        end
        default: state_d = ST_ACC;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_product_accumulator_serializer.sv
// Bench for product_accumulator_serializer: three parameterisations share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_product_accumulator_serializer;

  localparam int NI = 3;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [7:0] prod_in;

  logic       in_ready  [NI];
  logic       out_valid [NI];
  logic       out_last  [NI];
  logic       ovf       [NI];
  logic       busy      [NI];
  logic [7:0] out_data  [NI];

  always #5 clk = ~clk;

  product_accumulator_serializer u_def (
    .clk(clk), .rst(rst), .clr(clr), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(in_ready[0]), .out_data(out_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready), .out_last(out_last[0]), .ovf(ovf[0]), .busy(busy[0])
  );

  product_accumulator_serializer #(.ACC_W(8), .COUNT(2)) u_w8 (
    .clk(clk), .rst(rst), .clr(clr), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(in_ready[1]), .out_data(out_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready), .out_last(out_last[1]), .ovf(ovf[1]), .busy(busy[1])
  );

  product_accumulator_serializer #(.COUNT(1)) u_c1 (
    .clk(clk), .rst(rst), .clr(clr), .prod_in(prod_in), .in_valid(in_valid),
    .in_ready(in_ready[2]), .out_data(out_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready), .out_last(out_last[2]), .ovf(ovf[2]), .busy(busy[2])
  );

  // Reference model: running sum, product count and the result being sent
  int unsigned       mw [NI];
  int unsigned       mc [NI];
  longint unsigned   m_sum [NI];
  longint unsigned   m_res [NI];
  int unsigned       m_cnt [NI];
  int unsigned       m_idx [NI];
  bit                m_emit [NI];
  bit                m_ovf [NI];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] gd0[$];
  logic       gl0[$];
  logic [7:0] gd1[$];
  logic       gv1[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear(input int k);
    m_sum[k]  = 0;
    m_res[k]  = 0;
    m_cnt[k]  = 0;
    m_idx[k]  = 0;
    m_emit[k] = 1'b0;
    m_ovf[k]  = 1'b0;
  endtask

  task automatic model_step(input logic iv, input logic [7:0] p, input logic ordy, input logic c);
    longint unsigned s;
    longint unsigned lim;
    for (int k = 0; k < NI; k++) begin
      lim = 64'd1 << mw[k];
      if (c) begin
        model_clear(k);
      end else if (m_emit[k]) begin
        if (ordy) begin
          if (m_idx[k] == mw[k] / 8 - 1) model_clear(k);
          else m_idx[k]++;
        end
      end else if (iv) begin
        s = m_sum[k] + 64'(p);
        if (s >= lim) m_ovf[k] = 1'b1;
        m_sum[k] = s % lim;
        m_cnt[k]++;
        if (m_cnt[k] == mc[k]) begin
          m_emit[k] = 1'b1;
          m_res[k]  = m_sum[k];
          m_idx[k]  = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    longint unsigned b;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(!m_emit[k]));
      check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_emit[k]));
      check($sformatf("out_last[%0d]", k), 64'(out_last[k]),
            64'(m_emit[k] && (m_idx[k] == mw[k] / 8 - 1)));
      check($sformatf("ovf[%0d]", k), 64'(ovf[k]), 64'(m_ovf[k]));
      check($sformatf("busy[%0d]", k), 64'(busy[k]), 64'(m_emit[k] || (m_cnt[k] > 0)));
      if (m_emit[k]) begin
        b = (m_res[k] >> (8 * m_idx[k])) & 64'hff;
        check($sformatf("out_data[%0d]", k), 64'(out_data[k]), b);
      end
    end
  endtask

  // One clock: check current outputs, drive inputs, log handshakes, advance model
  task automatic cycle(input logic iv, input logic [7:0] p, input logic ordy, input logic c);
    check_outputs();
    in_valid  = iv;
    prod_in   = p;
    out_ready = ordy;
    clr       = c;
    if (out_valid[0] && ordy && !c) begin
      gd0.push_back(out_data[0]);
      gl0.push_back(out_last[0]);
    end
    if (out_valid[1] && ordy && !c) begin
      gd1.push_back(out_data[1]);
      gv1.push_back(ovf[1]);
    end
    model_step(iv, p, ordy, c);
    @(negedge clk);
  endtask

  task automatic feed(input logic [7:0] p, input logic ordy);
    cycle(1'b1, p, ordy, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'd0, 1'b1, 1'b0);
  endtask

  task automatic sync_clear();
    cycle(1'b0, 8'd0, 1'b1, 1'b1);
    gd0.delete();
    gl0.delete();
    gd1.delete();
    gv1.delete();
  endtask

  initial begin
    mw = '{16, 8, 16};
    mc = '{4, 2, 1};
    for (int k = 0; k < NI; k++) model_clear(k);

    // Reset held for two edges with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid  = 1'($urandom);
      prod_in   = 8'($urandom);
      out_ready = 1'($urandom);
      clr       = 1'($urandom);
      @(negedge clk);
    end
    for (int k = 0; k < NI; k++) begin
      check($sformatf("rst_in_ready[%0d]", k), 64'(in_ready[k]), 64'd1);
      check($sformatf("rst_out_valid[%0d]", k), 64'(out_valid[k]), 64'd0);
      check($sformatf("rst_out_data[%0d]", k), 64'(out_data[k]), 64'd0);
      check($sformatf("rst_out_last[%0d]", k), 64'(out_last[k]), 64'd0);
      check($sformatf("rst_ovf[%0d]", k), 64'(ovf[k]), 64'd0);
      check($sformatf("rst_busy[%0d]", k), 64'(busy[k]), 64'd0);
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    clr       = 1'b0;
    out_ready = 1'b1;

    // Max sum with defaults: 900 = 0x0384
    sync_clear();
    for (int i = 0; i < 4; i++) feed(8'd225, 1'b1);
    idle(2);
    check("t2_in_ready_after", 64'(in_ready[0]), 64'd1);
    idle(1);
    check("t2_n", 64'(gd0.size()), 64'd2);
    if (gd0.size() == 2) begin
      check("t2_b0", 64'(gd0[0]), 64'h84);
      check("t2_b1", 64'(gd0[1]), 64'h03);
      check("t2_l0", 64'(gl0[0]), 64'd0);
      check("t2_l1", 64'(gl0[1]), 64'd1);
    end

    // Backpressure holds the first byte while input pulses are ignored
    sync_clear();
    for (int i = 1; i <= 4; i++) feed(8'(i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t3_hold_data", 64'(out_data[0]), 64'h0a);
      check("t3_hold_ready", 64'(in_ready[0]), 64'd0);
      cycle(1'($urandom), 8'($urandom), 1'b0, 1'b0);
    end
    idle(3);
    check("t3_n", 64'(gd0.size()), 64'd2);
    if (gd0.size() == 2) begin
      check("t3_b0", 64'(gd0[0]), 64'h0a);
      check("t3_b1", 64'(gd0[1]), 64'h00);
    end

    // Valid gaps between products
    sync_clear();
    feed(8'd10, 1'b1);
    idle(1);
    feed(8'd20, 1'b1);
    idle(2);
    feed(8'd30, 1'b1);
    feed(8'd40, 1'b1);
    idle(3);
    check("t4_n", 64'(gd0.size()), 64'd2);
    if (gd0.size() == 2) begin
      check("t4_b0", 64'(gd0[0]), 64'h64);
      check("t4_b1", 64'(gd0[1]), 64'h00);
    end

    // 8-bit accumulator wraps and flags ovf, which clears for the next result
    sync_clear();
    feed(8'd200, 1'b1);
    feed(8'd100, 1'b1);
    idle(1);
    feed(8'd1, 1'b1);
    feed(8'd1, 1'b1);
    idle(2);
    check("t5_n", 64'(gd1.size()), 64'd2);
    if (gd1.size() == 2) begin
      check("t5_b0", 64'(gd1[0]), 64'h2c);
      check("t5_ovf0", 64'(gv1[0]), 64'd1);
      check("t5_b1", 64'(gd1[1]), 64'h02);
      check("t5_ovf1", 64'(gv1[1]), 64'd0);
    end

    // clr mid-accumulation discards the partial sum
    sync_clear();
    feed(8'd50, 1'b1);
    feed(8'd50, 1'b1);
    cycle(1'b1, 8'd7, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) feed(8'd1, 1'b1);
    idle(3);
    check("t6_n", 64'(gd0.size()), 64'd2);
    if (gd0.size() == 2) begin
      check("t6_b0", 64'(gd0[0]), 64'h04);
      check("t6_b1", 64'(gd0[1]), 64'h00);
    end

    // clr after the first byte drops the rest of the result
    sync_clear();
    for (int i = 1; i <= 4; i++) feed(8'(i), 1'b0);
    cycle(1'b0, 8'd0, 1'b1, 1'b0);
    cycle(1'b1, 8'd9, 1'b0, 1'b1);
    check("t6_clr_valid", 64'(out_valid[0]), 64'd0);
    check("t6_clr_busy", 64'(busy[0]), 64'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle(1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 99) == 0));
    check_outputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
